// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - two-player reaction-time tester main sequencer
// Times random waits and reactions on a 1 ms tick and averages 8 trials per player.
module reaction_ctrl #(
  parameter int   WAIT_MIN_MS = 1000,
  parameter logic PLAYER_A    = 1'b1,
  parameter logic PLAYER_B    = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1ms,
  input  logic       start_btn,
  input  logic       react_btn_A,
  input  logic       react_btn_B,
  output logic [2:0] machine_state,
  output logic       cur_player,
  output logic [2:0] test_turn_A,
  output logic [2:0] test_turn_B,
  output logic [9:0] avr_react_time_A,
  output logic [9:0] avr_react_time_B,
  output logic [9:0] react_time,
  output logic       stimulus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_CLR_CNT1 = 3'd2,
    S_START    = 3'd3,
    S_STORAGE  = 3'd4,
    S_CLR_CNT2 = 3'd5,
    S_AVERAGE  = 3'd6,
    S_COMPARE  = 3'd7
  } state_t;

  localparam logic [11:0] WAIT_MIN = 12'(WAIT_MIN_MS);
  localparam logic [9:0]  RT_MAX   = 10'd1023;

  state_t      state;
  state_t      next_state;
  logic [12:0] sum_a;
  logic [12:0] sum_b;
  logic [11:0] wait_cnt;
  logic [11:0] wait_tgt;
  logic [7:0]  lfsr;

  logic       is_a;
  logic       react;
  logic [2:0] cur_turn;
  logic       last_turn;
  logic       wait_done;

  logic game_start;
  logic sample_tgt;
  logic wait_inc;
  logic wait_clr;
  logic rt_clr;
  logic rt_inc;
  logic sum_add;
  logic turn_inc;
  logic avr_load;
  logic swap_b;

  // Only the active player's button counts; the other one is ignored everywhere.
  assign is_a          = (cur_player == PLAYER_A);
  assign react         = is_a ? react_btn_A : react_btn_B;
  assign cur_turn      = is_a ? test_turn_A : test_turn_B;
  assign last_turn     = (cur_turn == 3'd7);
  assign wait_done     = tick_1ms && (wait_cnt == wait_tgt - 12'd1);
  assign machine_state = state;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start_btn) next_state = S_WAIT;
      S_WAIT: begin
        if (react)          next_state = S_WAIT;
        else if (wait_done) next_state = S_CLR_CNT1;
      end
      S_CLR_CNT1: next_state = S_START;
      S_START:    if (react) next_state = S_STORAGE;
      S_STORAGE:  next_state = S_CLR_CNT2;
      S_CLR_CNT2: next_state = last_turn ? S_AVERAGE : S_WAIT;
      S_AVERAGE: begin
        if (!is_a)          next_state = S_COMPARE;
        else if (start_btn) next_state = S_WAIT;
      end
      S_COMPARE:  if (start_btn) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    game_start = 1'b0;
    sample_tgt = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    rt_clr     = 1'b0;
    rt_inc     = 1'b0;
    sum_add    = 1'b0;
    turn_inc   = 1'b0;
    avr_load   = 1'b0;
    swap_b     = 1'b0;
    case (state)
      S_IDLE: begin
        game_start = start_btn;
        sample_tgt = start_btn;
      end
      S_WAIT: begin
        sample_tgt = react;
        wait_inc   = tick_1ms && !react;
      end
      S_CLR_CNT1: begin
        rt_clr   = 1'b1;
        wait_clr = 1'b1;
      end
      // A tick coinciding with the press is dropped so the stored value is the pre-tick count.
      S_START:    rt_inc = tick_1ms && !react && (react_time != RT_MAX);
      S_STORAGE:  sum_add = 1'b1;
      S_CLR_CNT2: begin
        rt_clr     = 1'b1;
        turn_inc   = !last_turn;
        sample_tgt = !last_turn;
        avr_load   = last_turn;
      end
      S_AVERAGE: begin
        swap_b     = is_a && start_btn;
        sample_tgt = is_a && start_btn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      lfsr     <= 8'h01;
      stimulus <= 1'b0;
      wait_cnt <= 12'd0;
      wait_tgt <= 12'd0;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      stimulus <= (next_state == S_START);
      if (sample_tgt) begin
        wait_tgt <= WAIT_MIN + {2'b00, lfsr, 2'b00};
        wait_cnt <= 12'd0;
      end else if (wait_clr) begin
        wait_cnt <= 12'd0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      react_time <= 10'd0;
    end else if (rt_clr) begin
      react_time <= 10'd0;
    end else if (rt_inc) begin
      react_time <= react_time + 10'd1;
    end
  end

  // Per-player results; cleared only when a new game leaves IDLE.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cur_player       <= PLAYER_A;
      sum_a            <= 13'd0;
      sum_b            <= 13'd0;
      test_turn_A      <= 3'd0;
      test_turn_B      <= 3'd0;
      avr_react_time_A <= 10'd0;
      avr_react_time_B <= 10'd0;
    end else begin
      if (game_start) begin
        cur_player       <= PLAYER_A;
        sum_a            <= 13'd0;
        sum_b            <= 13'd0;
        test_turn_A      <= 3'd0;
        test_turn_B      <= 3'd0;
        avr_react_time_A <= 10'd0;
        avr_react_time_B <= 10'd0;
      end
      if (swap_b) begin
        cur_player <= PLAYER_B;
      end
      if (sum_add) begin
        if (is_a) sum_a <= sum_a + {3'b000, react_time};
        else      sum_b <= sum_b + {3'b000, react_time};
      end
      if (turn_inc) begin
        if (is_a) test_turn_A <= test_turn_A + 3'd1;
        else      test_turn_B <= test_turn_B + 3'd1;
      end
      if (avr_load) begin
        if (is_a) avr_react_time_A <= sum_a[12:3];
        else      avr_react_time_B <= sum_b[12:3];
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - self-checking bench for reaction_ctrl
// Vector table for the reset/idle corner, then trial-level model of whole games.
module tb_reaction_ctrl;

  localparam int WMIN = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       start_btn = 1'b0;
  logic       react_btn_A = 1'b0;
  logic       react_btn_B = 1'b0;
  logic [2:0] machine_state;
  logic       cur_player;
  logic [2:0] test_turn_A;
  logic [2:0] test_turn_B;
  logic [9:0] avr_react_time_A;
  logic [9:0] avr_react_time_B;
  logic [9:0] react_time;
  logic       stimulus;

  reaction_ctrl #(.WAIT_MIN_MS(WMIN)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .tick_1ms         (tick_1ms),
    .start_btn        (start_btn),
    .react_btn_A      (react_btn_A),
    .react_btn_B      (react_btn_B),
    .machine_state    (machine_state),
    .cur_player       (cur_player),
    .test_turn_A      (test_turn_A),
    .test_turn_B      (test_turn_B),
    .avr_react_time_A (avr_react_time_A),
    .avr_react_time_B (avr_react_time_B),
    .react_time       (react_time),
    .stimulus         (stimulus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_cur   = 1'b1;
  int   exp_tgt = 0;
  int   n_ticks = 0;
  int   m_sum   = 0;
  int   m_avr_a = 0;
  int   m_avr_b = 0;
  int   td[8];
  logic ts[8];
  logic [7:0] m_lfsr = 8'h01;

  // Reference pseudo-random source: the wait target is drawn from this sequence.
  always @(posedge clk) begin
    if (rstn) m_lfsr <= 8'h01;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic r, t, s, a, b;
    int   st, cur, stim, rt, ta;
  } vec_t;
  vec_t vec[9];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cur_turn();
    return m_cur ? int'(test_turn_A) : int'(test_turn_B);
  endfunction

  function automatic int cur_avr();
    return m_cur ? int'(avr_react_time_A) : int'(avr_react_time_B);
  endfunction

  // One clock with the given inputs; also tracks wait length against the modelled target.
  task automatic cyc(input logic r, input logic t, input logic s, input logic a, input logic b);
    int   ps;
    int   pl;
    logic rc;
    ps = int'(machine_state);
    pl = int'(m_lfsr);
    rc = m_cur ? a : b;
    rstn = r; tick_1ms = t; start_btn = s; react_btn_A = a; react_btn_B = b;
    @(negedge clk);
    rstn = 1'b0; tick_1ms = 1'b0; start_btn = 1'b0; react_btn_A = 1'b0; react_btn_B = 1'b0;
    if (!r && ps == 1 && t && !rc) n_ticks++;
    if (!r && machine_state == 3'd1 && (ps != 1 || rc)) begin
      exp_tgt = WMIN + 4 * pl;
      n_ticks = 0;
    end
    if (!r && ps == 1 && machine_state == 3'd2) chk("wait_len", n_ticks, exp_tgt);
  endtask

  task automatic noise(output logic oa, output logic ob);
    oa = !m_cur && ($urandom_range(0, 2) == 0);
    ob = m_cur && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_to_start(output int prev);
    logic oa, ob;
    prev = int'(machine_state);
    for (int i = 0; i < 3000 && machine_state != 3'd3; i++) begin
      prev = int'(machine_state);
      noise(oa, ob);
      cyc(0, 1, 0, oa, ob);
    end
    chk("reach_start", int'(machine_state), 3);
  endtask

  task automatic do_trial(input int d, input logic same_tick, input int k);
    int   prev;
    int   exp_rt;
    logic oa, ob;
    exp_rt = (d > 1023) ? 1023 : d;
    run_to_start(prev);
    if (machine_state != 3'd3) return;
    chk("pre_start_state", prev, 2);
    chk("stim_on", int'(stimulus), 1);
    chk("rt_at_start", int'(react_time), 0);
    chk("turn", cur_turn(), k);
    for (int i = 0; i < d; i++) begin
      noise(oa, ob);
      cyc(0, 1, 0, oa, ob);
    end
    chk("rt_live", int'(react_time), exp_rt);
    cyc(0, same_tick, 0, m_cur, !m_cur);
    chk("storage", int'(machine_state), 4);
    chk("rt_stored", int'(react_time), exp_rt);
    chk("stim_off", int'(stimulus), 0);
    m_sum += exp_rt;
    cyc(0, 0, 0, 0, 0);
    chk("clr_cnt2", int'(machine_state), 5);
    cyc(0, 0, 0, 0, 0);
    chk("after_clr2", int'(machine_state), (k == 7) ? 6 : 1);
    chk("rt_cleared", int'(react_time), 0);
    chk("turn_next", cur_turn(), (k == 7) ? 7 : k + 1);
  endtask

  task automatic play_player();
    m_sum = 0;
    for (int k = 0; k < 8; k++) do_trial(td[k], ts[k], k);
    if (m_cur) m_avr_a = m_sum / 8;
    else       m_avr_b = m_sum / 8;
    chk("avg_state", int'(machine_state), 6);
    chk("avr", cur_avr(), m_sum / 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int prev;
    vec[0] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[1] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[2] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    vec[3] = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    vec[4] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
    vec[5] = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    vec[6] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0};
    vec[7] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[8] = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0};

    @(negedge clk);
    m_cur = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(vec[i].r, vec[i].t, vec[i].s, vec[i].a, vec[i].b);
      chk("vec_state", int'(machine_state), vec[i].st);
      chk("vec_cur", int'(cur_player), vec[i].cur);
      chk("vec_stim", int'(stimulus), vec[i].stim);
      chk("vec_rt", int'(react_time), vec[i].rt);
      chk("vec_turn_a", int'(test_turn_A), vec[i].ta);
    end

    // Early press restarts the wait.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    chk("wait_hold", int'(machine_state), 1);
    cyc(0, 1, 0, 1, 0);
    chk("early_press", int'(machine_state), 1);

    // Game 1: A at 200, B at 150.
    for (int k = 0; k < 8; k++) begin td[k] = 200; ts[k] = 1'b0; end
    play_player();
    chk("avr_a_200", int'(avr_react_time_A), 200);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 1);
      chk("avg_hold", int'(machine_state), 6);
    end
    cyc(0, 0, 1, 0, 0);
    m_cur = 1'b0;
    chk("swap_state", int'(machine_state), 1);
    chk("swap_cur", int'(cur_player), 0);
    for (int k = 0; k < 8; k++) begin td[k] = 150; ts[k] = 1'b0; end
    play_player();
    cyc(0, 0, 0, 0, 0);
    chk("compare", int'(machine_state), 7);
    chk("cmp_avr_b", int'(avr_react_time_B), 150);
    chk("cmp_avr_a", int'(avr_react_time_A), 200);
    cyc(0, 1, 0, 1, 1);
    chk("cmp_hold", int'(machine_state), 7);
    cyc(0, 0, 1, 0, 0);
    chk("to_idle", int'(machine_state), 0);
    chk("idle_avr_a", int'(avr_react_time_A), m_avr_a);
    chk("idle_avr_b", int'(avr_react_time_B), m_avr_b);
    chk("idle_turn_a", int'(test_turn_A), 7);
    cyc(0, 0, 1, 0, 0);
    m_cur = 1'b1;
    chk("new_game", int'(machine_state), 1);
    chk("clr_avr_a", int'(avr_react_time_A), 0);
    chk("clr_avr_b", int'(avr_react_time_B), 0);
    chk("clr_turn_a", int'(test_turn_A), 0);
    chk("clr_turn_b", int'(test_turn_B), 0);
    chk("clr_cur", int'(cur_player), 1);

    // Game 2: saturation and a press coinciding with a tick.
    td[0] = 1500; ts[0] = 1'b1;
    for (int k = 1; k < 7; k++) begin td[k] = 1023; ts[k] = 1'($urandom_range(0, 1)); end
    td[7] = 0; ts[7] = 1'b1;
    play_player();
    chk("avr_sat", int'(avr_react_time_A), 895);

    // Reset in the middle of a reaction.
    cyc(0, 0, 1, 0, 0);
    m_cur = 1'b0;
    run_to_start(prev);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0, 0);
    chk("rt_300", int'(react_time), 300);
    cyc(1, 1, 0, 0, 1);
    m_cur = 1'b1;
    chk("rst_state", int'(machine_state), 0);
    chk("rst_rt", int'(react_time), 0);
    chk("rst_stim", int'(stimulus), 0);
    chk("rst_cur", int'(cur_player), 1);
    chk("rst_avr_a", int'(avr_react_time_A), 0);
    chk("rst_avr_b", int'(avr_react_time_B), 0);
    chk("rst_turn_a", int'(test_turn_A), 0);

    // Game 3: random reaction times.
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      td[k] = int'($urandom_range(0, 1100)); ts[k] = 1'($urandom_range(0, 1));
    end
    play_player();
    cyc(0, 0, 1, 0, 0);
    m_cur = 1'b0;
    for (int k = 0; k < 8; k++) begin
      td[k] = int'($urandom_range(0, 1100)); ts[k] = 1'($urandom_range(0, 1));
    end
    play_player();
    cyc(0, 0, 0, 0, 0);
    chk("rnd_compare", int'(machine_state), 7);
    chk("rnd_avr_a", int'(avr_react_time_A), m_avr_a);
    chk("rnd_avr_b", int'(avr_react_time_B), m_avr_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Main sequencer for the two-player reaction-time tester. It generates the 3-bit machine_state consumed by the RGB indicator and display logic, and selects the active player. It times random wait and reaction intervals on a 1 ms tick, then accumulates 8 trials per player. It publishes per-player turn counts and average reaction times, which drive the LED colour and brightness outputs.

Parameters:
WAIT_MIN_MS, 1000, minimum random pre-stimulus wait in ms (12-bit range; benches may shrink it)
PLAYER_A, 1'b1, cur_player encoding for player A
PLAYER_B, 1'b0, cur_player encoding for player B

Ports:
clk  input  1  system clock
rstn  input  1  reset; synchronous, active-high
tick_1ms  input  1  one-cycle pulse every 1 ms
start_btn  input  1  debounced one-cycle start/advance pulse
react_btn_A  input  1  debounced one-cycle reaction pulse, player A
react_btn_B  input  1  debounced one-cycle reaction pulse, player B
machine_state  output  3  IDLE=0 WAIT=1 CLR_CNT1=2 START=3 STORAGE=4 CLR_CNT2=5 AVERAGE=6 COMPARE=7
cur_player  output  1  active player
test_turn_A  output  3  index of player A's current trial, 0..7
test_turn_B  output  3  index of player B's current trial, 0..7
avr_react_time_A  output  10  player A average, ms
avr_react_time_B  output  10  player B average, ms
react_time  output  10  live reaction counter, ms
stimulus  output  1  high exactly while machine_state==START

Behaviour:
- Reset (rstn=1 at a clk edge) overrides everything, including mid-operation:
  - state is IDLE and cur_player is PLAYER_A.
  - Both turn counts, both averages, both 13-bit sums, react_time and the wait counter are 0.
  - The LFSR is 8'h01 and stimulus is 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle and never reaches all-zero.
- Wait target: on every entry to WAIT, wait_tgt = WAIT_MIN_MS + {lfsr,2'b00}, a 12-bit value. It is sampled in the cycle of the transition.
- "React" means the react button of cur_player. The other player's button is ignored in all states. start_btn is ignored outside IDLE and AVERAGE/COMPARE as listed below.
- IDLE:
  - Holds until start_btn.
  - On start_btn: clears sums, turns and averages; sets cur_player=A; goes to WAIT.
- WAIT:
  - wait_cnt increments on tick_1ms.
  - React (early press): wait_cnt is cleared, a new target is sampled, and the state stays WAIT.
  - Else, on a tick with wait_cnt==wait_tgt-1: go to CLR_CNT1.
  - React has priority over a simultaneous tick.
- CLR_CNT1: one cycle; react_time=0, wait_cnt=0; go to START.
- START:
  - stimulus=1. react_time increments on tick_1ms and saturates at 1023.
  - On react: go to STORAGE. The value stored is react_time as registered in that cycle; a tick in the same cycle is ignored.
  - There is no timeout. At saturation the state holds until react.
- STORAGE: one cycle; sum[cur] += react_time; go to CLR_CNT2.
- CLR_CNT2: one cycle; react_time=0.
  - If test_turn[cur]==7: go to AVERAGE.
  - Else: test_turn[cur]+=1, sample a new target, go to WAIT.
- AVERAGE:
  - First cycle: avr[cur] = sum[cur][12:3] (truncating divide by 8).
  - If cur==B: go to COMPARE on the next cycle.
  - If cur==A: hold until start_btn, then set cur_player=B and go to WAIT with a new target.
  - test_turn stays at 7 while in AVERAGE.
- COMPARE: hold; all results are frozen. On start_btn go to IDLE; nothing is cleared until the IDLE→WAIT transition.
- Arithmetic: sums are 13 bits; the maximum is 8×1023=8184, so there is no overflow.
- All outputs are registered. machine_state changes on the clk edge after the triggering input.

Test Plan:
1. Reset mid-START with react_time=300 → next cycle: machine_state=0, react_time=0, stimulus=0, cur_player=1, both avr=0.
2. WAIT_MIN_MS=2; start_btn, then react_btn_A in WAIT → state stays 1, wait_cnt=0. Then no press → CLR_CNT1 after wait_tgt ticks, followed by START with stimulus=1.
3. Player A, 8 trials, react after exactly 200 ticks each:
   - States go 3→4→5→1, with test_turn_A stepping 0..7.
   - The 8th trial ends in state 6 with avr_react_time_A=200.
   - react_btn_B presses throughout have no effect.
4. A trial with no press for 1500 ticks → react_time holds at 1023; react → STORAGE adds 1023. Trials of 1023 ×7 plus 0 ×1 → avr=895.
5. After A completes, start_btn → cur_player=0, state 1. Player B does 8 trials of 150 → state 6 for one cycle, then 7, with avr_react_time_B=150 and avr_react_time_A still 200.
6. In COMPARE, start_btn → IDLE with averages retained. A further start_btn → WAIT with both averages and turns at 0. react_btn and tick in the same START cycle → stored value equals the pre-tick react_time.
